winner_agreement_monitor: RTL and testbench
===========================================

Name: winner_agreement_monitor

Overview:
- Downstream consumer of two attention cores: the softmax reference pipeline and PST_core.
- Aligns their per-query winner streams, which arrive with different latencies, through two small FIFOs.
- Compares winners pairwise and accumulates agreement statistics for the winner-match-rate metric.
- Statistics are readable in place through registered count outputs.

Parameters:
- DEPTH, 8: entries per alignment FIFO (power of 2, ≥2).
- CNT_W, 16: width of every statistics counter.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: pulse; IDLE/DONE -> RUN.
- stop, in, 1: pulse; RUN -> DRAIN.
- clear, in, 1: synchronous clear of counters, FIFOs and flags.
- sm_valid, in, 1: softmax winner valid.
- sm_winner, in, 2: softmax winner index.
- pst_valid, in, 1: PST winner valid.
- pst_winner, in, 2: PST winner index.
- pair_valid, out, 1: one-cycle pulse when a pair has been compared.
- pair_match, out, 1: compare result; meaningful only with pair_valid.
- total_cnt, out, CNT_W: pairs compared.
- match_cnt, out, CNT_W: pairs with equal winners.
- unpaired_cnt, out, CNT_W: entries discarded at end of drain.
- ovf_sm, out, 1: sticky; softmax sample dropped on full FIFO.
- ovf_pst, out, 1: sticky; PST sample dropped on full FIFO.
- sat, out, 1: sticky; some counter saturated.
- busy, out, 1: state is RUN or DRAIN.
- done, out, 1: state is DONE.
- rd_idx, in, 4: confusion cell index = {sm_winner, pst_winner}.
- rd_data, out, CNT_W: confusion cell count, registered.

Behaviour:
- Reset: state IDLE, both FIFOs empty, all counters 0, all flags and pulses 0, rd_data 0.
- FSM transitions:
  - IDLE: start -> RUN.
  - RUN: stop -> DRAIN.
  - DRAIN: either FIFO empty -> DONE.
  - DONE: start -> RUN; counters keep accumulating.
  - start in RUN/DRAIN and stop outside RUN are ignored.
- Pushes happen only in RUN: sm_valid pushes sm_winner, pst_valid pushes pst_winner. Valids outside RUN are ignored.
- Pairing happens in RUN and DRAIN. When both FIFOs are non-empty, pop the head of each in the same cycle and compare.
  - pair_valid and pair_match are registered, 1 cycle after the pop.
  - Counters reflect the pair on that same cycle.
- One pop per FIFO per cycle. Push and pop of the same FIFO in one cycle are legal, including when the FIFO is full (net occupancy unchanged, no overflow).
- Full FIFO with push and no pop: sample dropped, matching ovf flag set.
- DRAIN -> DONE: remaining occupancy of the non-empty FIFO is added to unpaired_cnt (saturating). Both FIFOs are flushed in the transition cycle.
- All counters saturate at 2^CNT_W-1 and set sat; they never wrap.
- clear in any state:
  - zeroes counters, flags and FIFOs; returns to IDLE.
  - has priority over start, stop and valids in the same cycle; those samples are lost.
- rst mid-operation has the same effect as reset, with no partial updates.
- rd_data = cell[rd_idx], registered, 1-cycle latency. Reads have no side effects.

Optional Feature:
- AGREE_CONFUSION_EN defined: sixteen CNT_W saturating counters, cell[{sm,pst}] incremented per compared pair; rd_data reads them.
- Not defined: no confusion counters; rd_data is tied to 0. All other behaviour is identical.

Decomposition:
- Package agree_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE}
  - N_TOK = 4, IDX_W = 2, CELL_W = 4
  - a saturating-increment function.
- Sub-module agree_sync_fifo, instantiated twice. Interface: DEPTH x IDX_W, push/pop/full/empty/count, synchronous active-high reset plus flush.

Test Plan:
- start; 5 sm samples {0,1,2,3,1} at cycles 0-4, pst samples {0,2,2,3,0} at cycles 3-7; stop at cycle 10 -> total_cnt=5, match_cnt=3, unpaired_cnt=0, done=1.
- RUN: 10 sm samples with no pst, DEPTH=8 -> ovf_sm=1, FIFO holds 8; stop -> DONE in 1 cycle, unpaired_cnt=8.
- FIFO full and sm_valid+pst_valid in the same cycle -> pop and push succeed, ovf_sm stays 0, pair_valid pulses next cycle.
- CNT_W=4: 20 matching pairs -> total_cnt=match_cnt=15, sat=1.
- clear asserted together with sm_valid/pst_valid in RUN -> state IDLE, all counts 0, sample not counted.
- AGREE_CONFUSION_EN: pairs (sm,pst)=(2,1)x3 and (0,0)x2, rd_idx=9 -> rd_data=3 next cycle; rd_idx=0 -> 2. Without the macro -> rd_data=0.

Source files
------------

// File: rtl/agree_pkg.sv
// Shared types, sizes and the saturating-add helper for the winner agreement monitor.
package agree_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int N_TOK  = 4;  // number of distinct winner indices
  localparam int IDX_W  = 2;  // width of a winner index
  localparam int CELL_W = 4;  // width of a confusion cell index {sm, pst}

  // Adds amt to val, clamping at max_v. Returns {clamped, result}.
  // The clamped bit is set only when the true sum would exceed max_v.
  function automatic logic [32:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] amt,
                                          input logic [31:0] max_v);
    logic [32:0] sum;
    sum = {1'b0, val} + {1'b0, amt};
    if (sum > {1'b0, max_v}) return {1'b1, max_v};
    return {1'b0, sum[31:0]};
  endfunction

endpackage

// File: rtl/agree_sync_fifo.sv
// Small synchronous FIFO of winner indices with flush. The head entry is
// presented combinationally so it can be compared in the cycle it is popped.
// A push while full is accepted only when a pop happens in the same cycle.
module agree_sync_fifo
  import agree_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [IDX_W-1:0]         din,
  input  logic                     pop,
  output logic [IDX_W-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [IDX_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign count   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; flush empties the FIFO like a reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/winner_agreement_monitor.sv
// Aligns softmax and PST winner streams through two FIFOs, compares them
// pairwise and accumulates saturating agreement statistics.
// Optional macro AGREE_CONFUSION_EN adds a 4x4 confusion matrix readable
// through rd_idx/rd_data; without it rd_data stays 0.
module winner_agreement_monitor
  import agree_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              sm_valid,
  input  logic [IDX_W-1:0]  sm_winner,
  input  logic              pst_valid,
  input  logic [IDX_W-1:0]  pst_winner,
  output logic              pair_valid,
  output logic              pair_match,
  output logic [CNT_W-1:0]  total_cnt,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [CNT_W-1:0]  unpaired_cnt,
  output logic              ovf_sm,
  output logic              ovf_pst,
  output logic              sat,
  output logic              busy,
  output logic              done,
  input  logic [CELL_W-1:0] rd_idx,
  output logic [CNT_W-1:0]  rd_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] total_q, total_d, match_q, match_d, unpaired_q, unpaired_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d, rd_sel;
  logic             ovf_sm_q, ovf_sm_d, ovf_pst_q, ovf_pst_d, sat_q, sat_d;
  logic             pair_valid_q, pair_valid_d, pair_match_q, pair_match_d;

  logic             sm_full, sm_empty, pst_full, pst_empty;
  logic [AW:0]      sm_count, pst_count;
  logic [IDX_W-1:0] sm_head, pst_head;
  logic             active, sm_push, pst_push, pair_go, pair_eq, drain_end, flush;
  logic             cell_sat;
  logic [32:0]      tot_inc, mat_inc, unp_inc;

  // Clear wins over every other input in its cycle, so all actions are gated by it.
  assign active    = (state_q == RUN) || (state_q == DRAIN);
  assign sm_push   = (state_q == RUN) && sm_valid && !clear;
  assign pst_push  = (state_q == RUN) && pst_valid && !clear;
  assign pair_go   = active && !sm_empty && !pst_empty && !clear;
  assign pair_eq   = (sm_head == pst_head);
  assign drain_end = (state_q == DRAIN) && (sm_empty || pst_empty);
  assign flush     = clear || drain_end;

  assign tot_inc = sat_inc(32'(total_q), 32'd1, 32'(CNT_MAX));
  assign mat_inc = sat_inc(32'(match_q), 32'd1, 32'(CNT_MAX));
  // At most one FIFO is non-empty when draining ends, so the sum is its leftover.
  assign unp_inc = sat_inc(32'(unpaired_q), 32'(sm_count) + 32'(pst_count), 32'(CNT_MAX));

  agree_sync_fifo #(.DEPTH(DEPTH)) u_sm_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(sm_push), .din(sm_winner),
    .pop(pair_go), .dout(sm_head), .full(sm_full), .empty(sm_empty), .count(sm_count)
  );

  agree_sync_fifo #(.DEPTH(DEPTH)) u_pst_fifo (
    .clk(clk), .rst(rst), .flush(flush), .push(pst_push), .din(pst_winner),
    .pop(pair_go), .dout(pst_head), .full(pst_full), .empty(pst_empty), .count(pst_count)
  );

`ifdef AGREE_CONFUSION_EN
  logic [CNT_W-1:0]       cell_q [N_TOK*N_TOK];
  logic [N_TOK*N_TOK-1:0] cell_clamp;
  logic [CELL_W-1:0]      pair_idx;

  assign pair_idx = {sm_head, pst_head};

  for (genvar gi = 0; gi < N_TOK*N_TOK; gi++) begin : g_cell
    logic        hit;
    logic [32:0] cell_inc;
    assign hit            = pair_go && (pair_idx == CELL_W'(gi));
    assign cell_inc       = sat_inc(32'(cell_q[gi]), 32'd1, 32'(CNT_MAX));
    assign cell_clamp[gi] = hit && cell_inc[32];
    // One saturating counter per {sm, pst} combination.
    always_ff @(posedge clk) begin
      if (rst || clear) cell_q[gi] <= '0;
      else if (hit)     cell_q[gi] <= cell_inc[CNT_W-1:0];
    end
  end

  assign cell_sat = |cell_clamp;
  assign rd_sel   = cell_q[rd_idx];
`else
  logic unused_rd_idx;
  assign unused_rd_idx = ^rd_idx;
  assign cell_sat      = 1'b0;
  assign rd_sel        = '0;
`endif

  // Next-state, statistics and flag updates; clear overrides everything last.
  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    match_d      = match_q;
    unpaired_d   = unpaired_q;
    ovf_sm_d     = ovf_sm_q;
    ovf_pst_d    = ovf_pst_q;
    sat_d        = sat_q | cell_sat;
    pair_valid_d = pair_go;
    pair_match_d = pair_go && pair_eq;
    rd_data_d    = rd_sel;

    if (pair_go) begin
      total_d = tot_inc[CNT_W-1:0];
      if (tot_inc[32]) sat_d = 1'b1;
      if (pair_eq) begin
        match_d = mat_inc[CNT_W-1:0];
        if (mat_inc[32]) sat_d = 1'b1;
      end
    end
    // A push into a full FIFO survives only if a pop frees a slot that cycle.
    if (sm_push && sm_full && !pair_go)   ovf_sm_d  = 1'b1;
    if (pst_push && pst_full && !pair_go) ovf_pst_d = 1'b1;
    if (drain_end) begin
      unpaired_d = unp_inc[CNT_W-1:0];
      if (unp_inc[32]) sat_d = 1'b1;
    end

    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (stop)      state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = DONE;
      DONE:    if (start)     state_d = RUN;
      default:                state_d = IDLE;
    endcase

    if (clear) begin
      state_d      = IDLE;
      total_d      = '0;
      match_d      = '0;
      unpaired_d   = '0;
      ovf_sm_d     = 1'b0;
      ovf_pst_d    = 1'b0;
      sat_d        = 1'b0;
      pair_valid_d = 1'b0;
      pair_match_d = 1'b0;
      rd_data_d    = '0;
    end
  end

  // State and statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      total_q      <= '0;
      match_q      <= '0;
      unpaired_q   <= '0;
      ovf_sm_q     <= 1'b0;
      ovf_pst_q    <= 1'b0;
      sat_q        <= 1'b0;
      pair_valid_q <= 1'b0;
      pair_match_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      match_q      <= match_d;
      unpaired_q   <= unpaired_d;
      ovf_sm_q     <= ovf_sm_d;
      ovf_pst_q    <= ovf_pst_d;
      sat_q        <= sat_d;
      pair_valid_q <= pair_valid_d;
      pair_match_q <= pair_match_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign pair_valid   = pair_valid_q;
  assign pair_match   = pair_match_q;
  assign total_cnt    = total_q;
  assign match_cnt    = match_q;
  assign unpaired_cnt = unpaired_q;
  assign ovf_sm       = ovf_sm_q;
  assign ovf_pst      = ovf_pst_q;
  assign sat          = sat_q;
  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_winner_agreement_monitor.sv
// Bench for winner_agreement_monitor: two instances (CNT_W=16 and CNT_W=4)
// share one stimulus stream and are checked against a queue-based reference
// model. Honours AGREE_CONFUSION_EN for the rd_data expectation.
module tb_winner_agreement_monitor;

  localparam int DEPTH = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
`ifdef AGREE_CONFUSION_EN
  localparam bit CONF_EN = 1'b1;
`else
  localparam bit CONF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, stop, clear, sm_valid, pst_valid;
  logic [1:0] sm_winner, pst_winner;
  logic [3:0] rd_idx;

  logic        pv0, pm0, osm0, opst0, sat0, busy0, done0;
  logic [15:0] tot0, mat0, unp0, rd0;
  logic        pv1, pm1, osm1, opst1, sat1, busy1, done1;
  logic [3:0]  tot1, mat1, unp1, rd1;

  winner_agreement_monitor #(.DEPTH(DEPTH), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .sm_valid(sm_valid), .sm_winner(sm_winner), .pst_valid(pst_valid), .pst_winner(pst_winner),
    .pair_valid(pv0), .pair_match(pm0), .total_cnt(tot0), .match_cnt(mat0), .unpaired_cnt(unp0),
    .ovf_sm(osm0), .ovf_pst(opst0), .sat(sat0), .busy(busy0), .done(done0),
    .rd_idx(rd_idx), .rd_data(rd0)
  );

  winner_agreement_monitor #(.DEPTH(DEPTH), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
    .sm_valid(sm_valid), .sm_winner(sm_winner), .pst_valid(pst_valid), .pst_winner(pst_winner),
    .pair_valid(pv1), .pair_match(pm1), .total_cnt(tot1), .match_cnt(mat1), .unpaired_cnt(unp1),
    .ovf_sm(osm1), .ovf_pst(opst1), .sat(sat1), .busy(busy1), .done(done1),
    .rd_idx(rd_idx), .rd_data(rd1)
  );

  int total_n = 0;
  int bad_n   = 0;

  task automatic chk(string tag, int got, int exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model, one slot per instance.
  int m_max[2] = '{65535, 15};
  int m_st[2];
  int q_sm[2][$];
  int q_pst[2][$];
  int m_tot[2], m_mat[2], m_unp[2], m_rd[2];
  bit m_osm[2], m_opst[2], m_sat[2], m_pv[2], m_pm[2];
  int m_cell[2][16];

  function automatic int sadd(int k, int v, int a);
    if (v + a > m_max[k]) begin
      m_sat[k] = 1'b1;
      return m_max[k];
    end
    return v + a;
  endfunction

  task automatic model_reset(int k);
    m_st[k] = M_IDLE;
    q_sm[k].delete();
    q_pst[k].delete();
    m_tot[k] = 0; m_mat[k] = 0; m_unp[k] = 0; m_rd[k] = 0;
    m_osm[k] = 0; m_opst[k] = 0; m_sat[k] = 0; m_pv[k] = 0; m_pm[k] = 0;
    for (int i = 0; i < 16; i++) m_cell[k][i] = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step(int k);
    bit act, dend;
    int a, b;
    if (rst || clear) begin
      model_reset(k);
      return;
    end
    m_pv[k] = 0;
    m_pm[k] = 0;
    m_rd[k] = CONF_EN ? m_cell[k][rd_idx] : 0;
    act  = (m_st[k] == M_RUN) || (m_st[k] == M_DRAIN);
    dend = (m_st[k] == M_DRAIN) && (q_sm[k].size() == 0 || q_pst[k].size() == 0);
    if (act && q_sm[k].size() > 0 && q_pst[k].size() > 0) begin
      a = q_sm[k].pop_front();
      b = q_pst[k].pop_front();
      m_pv[k] = 1;
      m_pm[k] = (a == b);
      m_tot[k] = sadd(k, m_tot[k], 1);
      if (a == b) m_mat[k] = sadd(k, m_mat[k], 1);
      if (CONF_EN) m_cell[k][a*4+b] = sadd(k, m_cell[k][a*4+b], 1);
    end
    if (m_st[k] == M_RUN) begin
      if (sm_valid) begin
        if (q_sm[k].size() < DEPTH) q_sm[k].push_back(int'(sm_winner));
        else m_osm[k] = 1;
      end
      if (pst_valid) begin
        if (q_pst[k].size() < DEPTH) q_pst[k].push_back(int'(pst_winner));
        else m_opst[k] = 1;
      end
    end
    if (dend) begin
      m_unp[k] = sadd(k, m_unp[k], q_sm[k].size() + q_pst[k].size());
      q_sm[k].delete();
      q_pst[k].delete();
    end
    case (m_st[k])
      M_IDLE:  if (start) m_st[k] = M_RUN;
      M_RUN:   if (stop)  m_st[k] = M_DRAIN;
      M_DRAIN: if (dend)  m_st[k] = M_DONE;
      default: if (start) m_st[k] = M_RUN;
    endcase
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      int g_pv, g_pm, g_tot, g_mat, g_unp, g_osm, g_opst, g_sat, g_busy, g_done, g_rd;
      if (k == 0) begin
        g_pv = pv0; g_pm = pm0; g_tot = tot0; g_mat = mat0; g_unp = unp0; g_osm = osm0;
        g_opst = opst0; g_sat = sat0; g_busy = busy0; g_done = done0; g_rd = rd0;
      end else begin
        g_pv = pv1; g_pm = pm1; g_tot = tot1; g_mat = mat1; g_unp = unp1; g_osm = osm1;
        g_opst = opst1; g_sat = sat1; g_busy = busy1; g_done = done1; g_rd = rd1;
      end
      chk($sformatf("d%0d_pair_valid", k), g_pv, int'(m_pv[k]));
      if (m_pv[k]) chk($sformatf("d%0d_pair_match", k), g_pm, int'(m_pm[k]));
      chk($sformatf("d%0d_total", k), g_tot, m_tot[k]);
      chk($sformatf("d%0d_match", k), g_mat, m_mat[k]);
      chk($sformatf("d%0d_unpaired", k), g_unp, m_unp[k]);
      chk($sformatf("d%0d_ovf_sm", k), g_osm, int'(m_osm[k]));
      chk($sformatf("d%0d_ovf_pst", k), g_opst, int'(m_opst[k]));
      chk($sformatf("d%0d_sat", k), g_sat, int'(m_sat[k]));
      chk($sformatf("d%0d_busy", k), g_busy, int'(m_st[k] == M_RUN || m_st[k] == M_DRAIN));
      chk($sformatf("d%0d_done", k), g_done, int'(m_st[k] == M_DONE));
      chk($sformatf("d%0d_rd_data", k), g_rd, m_rd[k]);
    end
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; stop = 0; clear = 0;
    sm_valid = 0; pst_valid = 0; sm_winner = 0; pst_winner = 0; rd_idx = 0;
  endtask

  task automatic pulse_clear();
    clear = 1; cycle(); clear = 0;
  endtask

  task automatic pulse_start();
    start = 1; cycle(); start = 0;
  endtask

  task automatic wait_done(string tag);
    int n = 0;
    while (!done0 && n < 20) begin
      cycle();
      n++;
    end
    chk(tag, int'(done0), 1);
  endtask

  initial begin
    int smw[5] = '{0, 1, 2, 3, 1};
    int pw[5]  = '{0, 2, 2, 3, 0};
    int w;

    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    chk("rst_total", int'(tot0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_pair_valid", int'(pv0), 0);

    // Offset streams: five pairs, three of them matching.
    pulse_clear();
    pulse_start();
    for (int c = 0; c < 12; c++) begin
      sm_valid = (c < 5);
      if (c < 5) sm_winner = 2'(smw[c]);
      pst_valid = (c >= 3 && c < 8);
      if (c >= 3 && c < 8) pst_winner = 2'(pw[c-3]);
      stop = (c == 10);
      cycle();
    end
    idle_inputs();
    wait_done("t1_done");
    chk("t1_total", int'(tot0), 5);
    chk("t1_match", int'(mat0), 3);
    chk("t1_unpaired", int'(unp0), 0);

    // Overflow of the softmax FIFO, then drain discards eight entries.
    pulse_clear();
    pulse_start();
    for (int c = 0; c < 10; c++) begin
      sm_valid = 1; sm_winner = 2'($urandom_range(3));
      cycle();
    end
    idle_inputs();
    chk("t2_ovf_sm", int'(osm0), 1);
    chk("t2_ovf_pst", int'(opst0), 0);
    stop = 1; cycle(); stop = 0;
    cycle();
    chk("t2_done", int'(done0), 1);
    chk("t2_unpaired", int'(unp0), 8);

    // Push into a full FIFO while it pops: no overflow.
    pulse_clear();
    pulse_start();
    for (int c = 0; c < 8; c++) begin
      sm_valid = 1; sm_winner = 2'(c % 4);
      cycle();
    end
    sm_valid = 0; pst_valid = 1; pst_winner = 0;
    cycle();
    sm_valid = 1; sm_winner = 3; pst_valid = 1; pst_winner = 1;
    cycle();
    idle_inputs();
    chk("t3_pair_valid", int'(pv0), 1);
    chk("t3_ovf_sm", int'(osm0), 0);
    chk("t3_total", int'(tot0), 1);

    // Twenty matching pairs saturate the 4-bit instance.
    pulse_clear();
    pulse_start();
    for (int c = 0; c < 20; c++) begin
      w = $urandom_range(3);
      sm_valid = 1; pst_valid = 1; sm_winner = 2'(w); pst_winner = 2'(w);
      cycle();
    end
    idle_inputs();
    stop = 1; cycle(); stop = 0;
    wait_done("t4_done");
    chk("t4_total_w4", int'(tot1), 15);
    chk("t4_match_w4", int'(mat1), 15);
    chk("t4_sat_w4", int'(sat1), 1);
    chk("t4_total_w16", int'(tot0), 20);
    chk("t4_sat_w16", int'(sat0), 0);

    // Clear together with valids in RUN drops everything.
    pulse_clear();
    pulse_start();
    sm_valid = 1; sm_winner = 1;
    cycle();
    cycle();
    clear = 1; sm_valid = 1; pst_valid = 1;
    cycle();
    idle_inputs();
    chk("t5_busy", int'(busy0), 0);
    chk("t5_done", int'(done0), 0);
    chk("t5_total", int'(tot0), 0);
    pulse_start();
    stop = 1; cycle(); stop = 0;
    wait_done("t5_done_after");
    chk("t5_unpaired", int'(unp0), 0);

    // Confusion cells (2,1)x3 and (0,0)x2.
    pulse_clear();
    pulse_start();
    for (int c = 0; c < 5; c++) begin
      sm_valid = 1; pst_valid = 1;
      sm_winner  = (c < 3) ? 2'd2 : 2'd0;
      pst_winner = (c < 3) ? 2'd1 : 2'd0;
      cycle();
    end
    idle_inputs();
    stop = 1; cycle(); stop = 0;
    wait_done("t6_done");
    rd_idx = 4'd9;
    cycle();
    chk("t6_rd_cell9", int'(rd0), CONF_EN ? 3 : 0);
    rd_idx = 4'd0;
    cycle();
    chk("t6_rd_cell0", int'(rd0), CONF_EN ? 2 : 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst        = ($urandom_range(499) == 0);
      clear      = ($urandom_range(199) == 0);
      start      = ($urandom_range(19) == 0);
      stop       = ($urandom_range(29) == 0);
      sm_valid   = $urandom_range(1);
      pst_valid  = $urandom_range(1);
      sm_winner  = 2'($urandom_range(3));
      pst_winner = ($urandom_range(1) == 1) ? sm_winner : 2'($urandom_range(3));
      rd_idx     = 4'($urandom_range(15));
      cycle();
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule
